// File: rtl/quantoniumos_job_dispatcher.sv
// Single-job dispatcher for the unified crypto core: launches one job at a time,
// supervises it with a watchdog, resets a hung core and hands back a tagged result.
module quantoniumos_job_dispatcher #(
  parameter int TIMEOUT_CYCLES = 200000,
  parameter int RECOVER_CYCLES = 4,
  parameter int TAG_W          = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             job_valid,
  output logic             job_ready,
  input  logic [2:0]       job_mode,
  input  logic [255:0]     job_key,
  input  logic [127:0]     job_data,
  input  logic [TAG_W-1:0] job_tag,
  output logic             core_start,
  output logic [2:0]       core_mode,
  output logic [255:0]     core_master_key,
  output logic [127:0]     core_data_in,
  output logic             core_reset,
  input  logic [255:0]     core_data_out,
  input  logic             core_done,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [255:0]     res_data,
  output logic [TAG_W-1:0] res_tag,
  output logic [1:0]       res_status,
  output logic [15:0]      jobs_ok,
  output logic [15:0]      jobs_timeout
);

  localparam int MAX_COUNT = (TIMEOUT_CYCLES > RECOVER_CYCLES) ? TIMEOUT_CYCLES : RECOVER_CYCLES;
  localparam int CNT_W     = (MAX_COUNT > 1) ? $clog2(MAX_COUNT) : 1;
  localparam logic [CNT_W-1:0] WAIT_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] RECOVER_LAST = CNT_W'(RECOVER_CYCLES - 1);

  localparam logic [1:0] STATUS_OK      = 2'd0;
  localparam logic [1:0] STATUS_TIMEOUT = 2'd1;
  localparam logic [1:0] STATUS_BADMODE = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT,
    ST_RECOVER,
    ST_RESULT
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             accept, bad_mode, done_hit, timeout_hit, release_res;
  logic             core_rst_hold;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // One counter serves both the WAIT watchdog and the RECOVER hold time.
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    accept      = 1'b0;
    bad_mode    = 1'b0;
    done_hit    = 1'b0;
    timeout_hit = 1'b0;
    release_res = 1'b0;
    case (state)
      ST_IDLE: begin
        if (job_valid) begin
          accept = 1'b1;
          if (job_mode[2]) begin
            bad_mode   = 1'b1;
            state_next = ST_RESULT;
          end else begin
            state_next = ST_LAUNCH;
          end
        end
      end
      ST_LAUNCH: begin
        state_next = ST_WAIT;
        cnt_next   = '0;
      end
      ST_WAIT: begin
        if (core_done) begin
          done_hit   = 1'b1;
          state_next = ST_RESULT;
        end else if (cnt == WAIT_LAST) begin
          state_next = ST_RECOVER;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      ST_RECOVER: begin
        if (cnt == RECOVER_LAST) begin
          timeout_hit = 1'b1;
          state_next  = ST_RESULT;
          cnt_next    = '0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      ST_RESULT: begin
        if (res_ready) begin
          release_res = 1'b1;
          state_next  = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign job_ready  = (state == ST_IDLE);
  assign core_start = (state == ST_LAUNCH);
  assign res_valid  = (state == ST_RESULT);
  // The core stays in reset through our own reset and one edge beyond it.
  assign core_reset = core_rst_hold | (state == ST_RECOVER);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) core_rst_hold <= 1'b1;
    else          core_rst_hold <= 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      core_mode       <= '0;
      core_master_key <= '0;
      core_data_in    <= '0;
      res_tag         <= '0;
      res_data        <= '0;
      res_status      <= STATUS_OK;
      jobs_ok         <= '0;
      jobs_timeout    <= '0;
    end else begin
      if (accept) begin
        core_mode       <= job_mode;
        core_master_key <= job_key;
        core_data_in    <= job_data;
        res_tag         <= job_tag;
      end
      if (bad_mode) begin
        res_data   <= '0;
        res_status <= STATUS_BADMODE;
      end else if (done_hit) begin
        res_data   <= core_data_out;
        res_status <= STATUS_OK;
      end else if (timeout_hit) begin
        res_data   <= '0;
        res_status <= STATUS_TIMEOUT;
      end
      if (release_res && res_status == STATUS_OK && jobs_ok != 16'hFFFF)
        jobs_ok <= jobs_ok + 16'd1;
      if (release_res && res_status == STATUS_TIMEOUT && jobs_timeout != 16'hFFFF)
        jobs_timeout <= jobs_timeout + 16'd1;
    end
  end

endmodule

// File: tb/tb_quantoniumos_job_dispatcher.sv
// Randomized self-checking bench: each job's outcome is predicted from its mode and the
// delay the model core uses before raising done, then compared cycle by cycle.
module tb_quantoniumos_job_dispatcher;

  localparam int TMO = 16;
  localparam int RCV = 4;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         job_valid;
  logic         job_ready;
  logic [2:0]   job_mode;
  logic [255:0] job_key;
  logic [127:0] job_data;
  logic [7:0]   job_tag;
  logic         core_start;
  logic [2:0]   core_mode;
  logic [255:0] core_master_key;
  logic [127:0] core_data_in;
  logic         core_reset;
  logic [255:0] core_data_out;
  logic         core_done;
  logic         res_valid;
  logic         res_ready;
  logic [255:0] res_data;
  logic [7:0]   res_tag;
  logic [1:0]   res_status;
  logic [15:0]  jobs_ok;
  logic [15:0]  jobs_timeout;

  int vectors = 0;
  int miscompares = 0;
  int exp_ok = 0;
  int exp_to = 0;

  always #5 clk = ~clk;

  quantoniumos_job_dispatcher #(
    .TIMEOUT_CYCLES(TMO),
    .RECOVER_CYCLES(RCV),
    .TAG_W(8)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .job_valid(job_valid), .job_ready(job_ready), .job_mode(job_mode),
    .job_key(job_key), .job_data(job_data), .job_tag(job_tag),
    .core_start(core_start), .core_mode(core_mode), .core_master_key(core_master_key),
    .core_data_in(core_data_in), .core_reset(core_reset),
    .core_data_out(core_data_out), .core_done(core_done),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_tag(res_tag), .res_status(res_status),
    .jobs_ok(jobs_ok), .jobs_timeout(jobs_timeout)
  );

  function automatic logic [255:0] rand256();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // delay = cycles after the core_start cycle at which the model core raises done
  // (0 means during the start cycle itself, which the dispatcher must ignore).
  task automatic run_job(input logic [2:0] mode, input logic [255:0] key, input logic [127:0] data,
                         input logic [7:0] tag, input int delay, input logic [255:0] dout,
                         input int hold, input bit valid_in_hold);
    int exp_lat, exp_status, starts, resets, lat, c;
    logic [255:0] exp_data;
    if (mode >= 3'd4) begin
      exp_lat = 0; exp_status = 2; exp_data = '0;
    end else if (delay >= 1 && delay <= TMO) begin
      exp_lat = delay + 1; exp_status = 0; exp_data = dout;
    end else begin
      exp_lat = TMO + RCV + 1; exp_status = 1; exp_data = '0;
    end

    job_valid = 1'b1; job_mode = mode; job_key = key; job_data = data; job_tag = tag;
    vectors++;
    if (job_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL accept_ready: job_ready=%b required 1", job_ready);
    end
    step();
    job_valid = 1'b0;
    job_mode = 3'($urandom); job_key = rand256(); job_data = rand256()[127:0]; job_tag = 8'($urandom);

    starts = 0; resets = 0; lat = -1; c = 0;
    while (lat < 0 && c < 60) begin
      if (res_valid === 1'b1) begin
        lat = c;
      end else begin
        if (core_start === 1'b1) starts++;
        if (core_reset === 1'b1) resets++;
        core_done     = (c == delay);
        core_data_out = (c == delay) ? dout : rand256();
        step();
        c++;
      end
    end
    core_done = 1'b0;

    vectors++;
    if (lat != exp_lat) begin
      miscompares++;
      $display("FAIL latency: res_valid after %0d cycles, required %0d (mode %0d delay %0d)", lat, exp_lat, mode, delay);
    end
    vectors++;
    if (starts != ((mode >= 3'd4) ? 0 : 1)) begin
      miscompares++;
      $display("FAIL core_start_count: %0d pulses, required %0d", starts, (mode >= 3'd4) ? 0 : 1);
    end
    vectors++;
    if (resets != ((exp_status == 1) ? RCV : 0)) begin
      miscompares++;
      $display("FAIL core_reset_cycles: %0d, required %0d", resets, (exp_status == 1) ? RCV : 0);
    end
    vectors++;
    if (res_data !== exp_data || res_tag !== tag || res_status !== 2'(exp_status)) begin
      miscompares++;
      $display("FAIL result: data=%h tag=%h status=%0d, required data=%h tag=%h status=%0d",
               res_data, res_tag, res_status, exp_data, tag, exp_status);
    end
    vectors++;
    if (core_mode !== mode || core_master_key !== key || core_data_in !== data) begin
      miscompares++;
      $display("FAIL core_inputs: mode=%0d key=%h data=%h, required mode=%0d key=%h data=%h",
               core_mode, core_master_key, core_data_in, mode, key, data);
    end

    res_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      job_valid = valid_in_hold;
      job_mode = 3'($urandom); job_key = rand256(); job_tag = 8'($urandom);
      core_done = 1'($urandom); core_data_out = rand256();
      step();
      vectors++;
      if (res_valid !== 1'b1 || job_ready !== 1'b0 || core_start !== 1'b0 || res_data !== exp_data ||
          res_tag !== tag || res_status !== 2'(exp_status) || core_mode !== mode || core_master_key !== key) begin
        miscompares++;
        $display("FAIL hold_stable: cycle %0d valid=%b ready=%b start=%b data=%h tag=%h status=%0d, required valid=1 ready=0 start=0 data=%h tag=%h status=%0d",
                 h, res_valid, job_ready, core_start, res_data, res_tag, res_status, exp_data, tag, exp_status);
      end
    end

    core_done = 1'b0;
    res_ready = 1'b1;
    job_valid = valid_in_hold;
    step();
    res_ready = 1'b0;
    job_valid = 1'b0;
    if (exp_status == 0 && exp_ok < 16'hFFFF) exp_ok++;
    if (exp_status == 1 && exp_to < 16'hFFFF) exp_to++;
    vectors++;
    if (job_ready !== 1'b1 || res_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL release: job_ready=%b res_valid=%b, required 1 0", job_ready, res_valid);
    end
    vectors++;
    if (jobs_ok !== 16'(exp_ok) || jobs_timeout !== 16'(exp_to)) begin
      miscompares++;
      $display("FAIL counters: ok=%0d timeout=%0d, required ok=%0d timeout=%0d", jobs_ok, jobs_timeout, exp_ok, exp_to);
    end
    $display("job mode=%0d tag=%h delay=%0d -> status=%0d latency=%0d ok=%0d to=%0d",
             mode, tag, delay, res_status, lat, jobs_ok, jobs_timeout);
  endtask

  task automatic check_reset_values(input string name);
    vectors++;
    if (core_reset !== 1'b1 || core_start !== 1'b0 || res_valid !== 1'b0 || res_data !== '0 ||
        res_tag !== '0 || res_status !== 2'd0 || core_mode !== '0 || core_master_key !== '0 ||
        core_data_in !== '0 || jobs_ok !== '0 || jobs_timeout !== '0 || job_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s: core_reset=%b start=%b res_valid=%b res_data=%h tag=%h status=%0d mode=%0d ok=%0d to=%0d ready=%b, required reset values",
               name, core_reset, core_start, res_valid, res_data, res_tag, res_status, core_mode, jobs_ok, jobs_timeout, job_ready);
    end
  endtask

  task automatic release_reset_and_check(input string name);
    reset_n = 1'b1;
    #1;
    vectors++;
    if (core_reset !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_hold: core_reset=%b before first edge, required 1", name, core_reset);
    end
    step();
    vectors++;
    if (core_reset !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_deassert: core_reset=%b after first edge, required 0", name, core_reset);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; job_valid = 1'b0; job_mode = '0; job_key = '0; job_data = '0; job_tag = '0;
    core_done = 1'b0; core_data_out = '0; res_ready = 1'b0;
    step(); step();
    check_reset_values("reset_state");
    release_reset_and_check("reset_release");
    $display("reset: core_reset=%b job_ready=%b", core_reset, job_ready);
  endtask

  task automatic test_basic();
    logic [255:0] a5;
    a5 = {32{8'hA5}};
    run_job(3'd0, rand256(), 128'h000102030405060708090A0B0C0D0E0F, 8'h11, 10, a5, 2, 1'b0);
  endtask

  task automatic test_badmode();
    run_job(3'd5, rand256(), rand256()[127:0], 8'h22, 3, rand256(), 3, 1'b0);
  endtask

  task automatic test_timeout();
    run_job(3'd1, rand256(), rand256()[127:0], 8'h33, 0, rand256(), 1, 1'b0);
    run_job(3'd2, rand256(), rand256()[127:0], 8'h34, TMO + 1, rand256(), 1, 1'b0);
  endtask

  task automatic test_done_at_limit();
    run_job(3'd3, rand256(), rand256()[127:0], 8'h44, TMO, rand256(), 1, 1'b0);
    run_job(3'd0, rand256(), rand256()[127:0], 8'h45, 1, rand256(), 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_job(3'd1, rand256(), rand256()[127:0], 8'h55, 5, rand256(), 20, 1'b1);
    run_job(3'd6, rand256(), rand256()[127:0], 8'h56, 2, rand256(), 0, 1'b0);
    run_job(3'd2, rand256(), rand256()[127:0], 8'h57, 7, rand256(), 0, 1'b0);
  endtask

  task automatic test_random();
    for (int j = 0; j < 14; j++)
      run_job(3'($urandom), rand256(), rand256()[127:0], 8'($urandom), int'($urandom_range(0, 22)),
              rand256(), int'($urandom_range(0, 4)), 1'($urandom));
  endtask

  task automatic test_reset_midjob();
    bit seen;
    job_valid = 1'b1; job_mode = 3'd1; job_key = rand256(); job_data = rand256()[127:0]; job_tag = 8'h66;
    step();
    job_valid = 1'b0;
    for (int i = 0; i < 6; i++) step();
    reset_n = 1'b0;
    #1;
    check_reset_values("midjob_reset");
    exp_ok = 0; exp_to = 0;
    step();
    release_reset_and_check("midjob_release");
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      core_done = 1'($urandom);
      if (res_valid === 1'b1 || core_start === 1'b1) seen = 1'b1;
      step();
    end
    core_done = 1'b0;
    vectors++;
    if (seen) begin
      miscompares++;
      $display("FAIL midjob_no_result: res_valid or core_start seen after aborted job, required none");
    end
    $display("midjob reset: aborted job produced no result");
    run_job(3'd0, rand256(), rand256()[127:0], 8'h67, 4, rand256(), 1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_badmode();
    test_timeout();
    test_done_at_limit();
    test_back_to_back();
    test_random();
    test_reset_midjob();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
